// File: rtl/frame_tx_pkg.sv
//------------------------------------------------------------------------------
// Module      : frame_tx_pkg
// Description : Shared state encodings and sync-marker constants for 101 framing.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package frame_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_DATA = 3'd2,
        ST_PAR  = 3'd3,
        ST_GAP  = 3'd4
    } tx_state_t;

    localparam logic [2:0] c_sync_marker = 3'b101;
    localparam int         c_sync_len    = 3;

    // Marker bit at position idx, counted from the first bit on the line.
    function automatic logic sync_bit(input logic [1:0] idx);
        case (idx)
            2'd0:    return c_sync_marker[2];
            2'd1:    return c_sync_marker[1];
            default: return c_sync_marker[0];
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/piso_shift.sv
//------------------------------------------------------------------------------
// Module      : piso_shift
// Description : Parallel-load shift register presenting its MSB first.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module piso_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_din,
    output logic             o_msb
);

    logic [WIDTH-1:0] r_sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr <= '0;
        end else if (i_load) begin
            r_sr <= i_din;
        end else if (i_shift) begin
            r_sr <= r_sr << 1;
        end
    end

    assign o_msb = r_sr[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/frame_tx_101.sv
//------------------------------------------------------------------------------
// Module      : frame_tx_101
// Description : Serial frame transmitter: 101 marker, payload MSB first, parity, guard.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module frame_tx_101
    import frame_tx_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              OP,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state
);

    localparam int                 c_cnt_w     = $clog2(DATA_W + 1);
    localparam logic [c_cnt_w-1:0] c_last_bit  = c_cnt_w'(DATA_W - 1);
    localparam logic [1:0]         c_mark_last = 2'(c_sync_len - 1);

    tx_state_t          r_state;
    logic [1:0]         r_mark_cnt;
    logic [c_cnt_w-1:0] r_bit_cnt;
    logic               r_parity;
    logic               r_op;
    logic               r_busy;
    logic               r_done;
    logic               w_load;
    logic               w_shift;
    logic               w_msb;

    assign w_load  = (r_state == ST_IDLE) && start;
    // Advance the payload whenever its current MSB has just been moved onto OP.
    assign w_shift = ((r_state == ST_PRE) && (r_mark_cnt == c_mark_last)) ||
                     ((r_state == ST_DATA) && (r_bit_cnt != c_last_bit));

    piso_shift #(
        .WIDTH (DATA_W)
    ) u_piso (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_din   (data),
        .o_msb   (w_msb)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_mark_cnt <= '0;
            r_bit_cnt  <= '0;
            r_parity   <= 1'b0;
            r_op       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_PRE;
                        r_mark_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_parity   <= ^data;
                        r_op       <= sync_bit(2'd0);
                        r_busy     <= 1'b1;
                    end
                end
                ST_PRE: begin
                    if (r_mark_cnt == c_mark_last) begin
                        r_state <= ST_DATA;
                        r_op    <= w_msb;
                    end else begin
                        r_mark_cnt <= r_mark_cnt + 2'd1;
                        r_op       <= sync_bit(r_mark_cnt + 2'd1);
                    end
                end
                ST_DATA: begin
                    if (r_bit_cnt == c_last_bit) begin
                        if (PARITY_EN != 0) begin
                            r_state <= ST_PAR;
                            r_op    <= r_parity;
                        end else begin
                            r_state <= ST_GAP;
                            r_op    <= 1'b0;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_op      <= w_msb;
                    end
                end
                ST_PAR: begin
                    r_state <= ST_GAP;
                    r_op    <= 1'b0;
                end
                ST_GAP: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_op    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign OP    = r_op;
    assign busy  = r_busy;
    assign done  = r_done;
    assign state = r_state;

endmodule

`default_nettype wire
